time_counter: RTL and testbench



---
 rtl/time_pkg.sv | 93 +++++++++
 rtl/time_counter_if.sv | 22 ++
 rtl/tick_gen.sv | 31 +++
 rtl/time_counter.sv | 69 ++++++
 tb/tb_time_counter.sv | 321 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/time_pkg.sv
// Shared types and BCD MM:SS arithmetic for the stopwatch/timer datapath.
package time_pkg;

  typedef logic [3:0] bcd_digit_t;

  typedef struct packed {
    bcd_digit_t min_tens;
    bcd_digit_t min_ones;
    bcd_digit_t sec_tens;
    bcd_digit_t sec_ones;
  } time_bcd_t;

  localparam bcd_digit_t  SEC_TENS_MAX = 4'd5;
  localparam bcd_digit_t  DIGIT_MAX    = 4'd9;
  localparam logic [15:0] TIME_MAX     = 16'h9959;

  // +1 second with full cascade; saturates at 99:59.
  function automatic time_bcd_t bcd_inc(input time_bcd_t t);
    time_bcd_t r;
    r = t;
    if (t != time_bcd_t'(TIME_MAX)) begin
      if (t.sec_ones != DIGIT_MAX) begin
        r.sec_ones = t.sec_ones + 4'd1;
      end else begin
        r.sec_ones = 4'd0;
        if (t.sec_tens != SEC_TENS_MAX) begin
          r.sec_tens = t.sec_tens + 4'd1;
        end else begin
          r.sec_tens = 4'd0;
          if (t.min_ones != DIGIT_MAX) begin
            r.min_ones = t.min_ones + 4'd1;
          end else begin
            r.min_ones = 4'd0;
            r.min_tens = t.min_tens + 4'd1;
          end
        end
      end
    end
    return r;
  endfunction

  // -1 second with borrow from minutes; holds at 00:00.
  function automatic time_bcd_t bcd_dec(input time_bcd_t t);
    time_bcd_t r;
    r = t;
    if (t != '0) begin
      if (t.sec_ones != 4'd0) begin
        r.sec_ones = t.sec_ones - 4'd1;
      end else begin
        r.sec_ones = DIGIT_MAX;
        if (t.sec_tens != 4'd0) begin
          r.sec_tens = t.sec_tens - 4'd1;
        end else begin
          r.sec_tens = SEC_TENS_MAX;
          if (t.min_ones != 4'd0) begin
            r.min_ones = t.min_ones - 4'd1;
          end else begin
            r.min_ones = DIGIT_MAX;
            r.min_tens = t.min_tens - 4'd1;
          end
        end
      end
    end
    return r;
  endfunction

  // Seconds field only: 59 wraps to 00 without touching minutes.
  function automatic time_bcd_t bcd_sec_adj(input time_bcd_t t);
    time_bcd_t r;
    r = t;
    if (t.sec_ones != DIGIT_MAX) begin
      r.sec_ones = t.sec_ones + 4'd1;
    end else begin
      r.sec_ones = 4'd0;
      r.sec_tens = (t.sec_tens == SEC_TENS_MAX) ? 4'd0 : t.sec_tens + 4'd1;
    end
    return r;
  endfunction

  // Minutes field only: 99 wraps to 00.
  function automatic time_bcd_t bcd_min_adj(input time_bcd_t t);
    time_bcd_t r;
    r = t;
    if (t.min_ones != DIGIT_MAX) begin
      r.min_ones = t.min_ones + 4'd1;
    end else begin
      r.min_ones = 4'd0;
      r.min_tens = (t.min_tens == DIGIT_MAX) ? 4'd0 : t.min_tens + 4'd1;
    end
    return r;
  endfunction

endpackage

// File: rtl/time_counter_if.sv
// Strobes from the mode FSM and the counter's time/tick/flag results.
interface time_counter_if;
  logic        clear;
  logic        enable;
  logic        enable_increment;
  logic        enable_decrement;
  logic        adj_sec;
  logic        adj_min;
  logic [15:0] time_bcd;
  logic        tick;
  logic        flag;

  modport master (
    output clear, enable, enable_increment, enable_decrement, adj_sec, adj_min,
    input  time_bcd, tick, flag
  );

  modport slave (
    input  clear, enable, enable_increment, enable_decrement, adj_sec, adj_min,
    output time_bcd, tick, flag
  );
endinterface

// File: rtl/tick_gen.sv
// One-second prescaler: registered tick is high while the count sits at TICK_DIV-1.
module tick_gen #(
  parameter int TICK_DIV = 10_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic run,
  output logic tick
);
  localparam int CNT_W = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TICK_DIV - 1);

  logic [CNT_W-1:0] cnt_p0;
  logic [CNT_W-1:0] cnt_nxt;

  always_comb begin
    cnt_nxt = '0;
    if (run && (cnt_p0 != CNT_MAX)) cnt_nxt = cnt_p0 + 1'b1;
  end

  // Stage p0: count and its terminal-value tick registered together.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_p0 <= '0;
      tick   <= 1'b0;
    end else begin
      cnt_p0 <= cnt_nxt;
      tick   <= run && (cnt_nxt == CNT_MAX);
    end
  end
endmodule

// File: rtl/time_counter.sv
// BCD MM:SS counter driven by the stopwatch/timer FSM strobes.
module time_counter
  import time_pkg::*;
#(
  parameter int TICK_DIV = 10_000_000
) (
  input logic           clk,
  input logic           rst,
  time_counter_if.slave bus
);
  logic      mode_dec;
  logic      mode_up;
  logic      mode_inc;
  logic      run;
  logic      tick;
  time_bcd_t time_p0;
  time_bcd_t time_nxt;
  logic      flag_p0;
  logic      flag_nxt;

  // Only the highest-priority asserted mode acts; clear outranks all.
  assign mode_dec = !bus.clear && bus.enable_decrement;
  assign mode_up  = !bus.clear && !bus.enable_decrement && bus.enable;
  assign mode_inc = !bus.clear && !bus.enable_decrement && !bus.enable && bus.enable_increment;
  assign run      = mode_dec || mode_up;

  tick_gen #(.TICK_DIV(TICK_DIV)) u_tick_gen (
    .clk  (clk),
    .rst  (rst),
    .run  (run),
    .tick (tick)
  );

  always_comb begin
    time_nxt = time_p0;
    flag_nxt = flag_p0;
    if (bus.clear) begin
      time_nxt = '0;
      flag_nxt = 1'b0;
    end else if (mode_dec) begin
      if (time_p0 == '0) begin
        flag_nxt = 1'b1;
      end else if (tick) begin
        time_nxt = bcd_dec(time_p0);
        if (time_nxt == '0) flag_nxt = 1'b1;
      end
    end else if (mode_up) begin
      if (tick) time_nxt = bcd_inc(time_p0);
    end else if (mode_inc) begin
      if (bus.adj_sec) time_nxt = bcd_sec_adj(time_nxt);
      if (bus.adj_min) time_nxt = bcd_min_adj(time_nxt);
    end
  end

  // Stage p0: registered time value and sticky time-up flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      time_p0 <= '0;
      flag_p0 <= 1'b0;
    end else begin
      time_p0 <= time_nxt;
      flag_p0 <= flag_nxt;
    end
  end

  assign bus.time_bcd = time_p0;
  assign bus.flag     = flag_p0;
  assign bus.tick     = tick;
endmodule

// File: tb/tb_time_counter.sv
// Randomized and directed bench for time_counter against a seconds-based reference model.
module tb_time_counter;
  localparam int TICK_DIV = 4;

  logic clk;
  logic rst;
  int   checks;
  int   failures;

  // Reference state: whole seconds, prescaler edge count, flag.
  int   m_total;
  int   m_pre;
  bit   m_flag;

  time_counter_if bus ();

  time_counter #(.TICK_DIV(TICK_DIV)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [15:0] to_bcd(input int total);
    int mm;
    int ss;
    mm = total / 60;
    ss = total % 60;
    return {4'(mm / 10), 4'(mm % 10), 4'(ss / 10), 4'(ss % 10)};
  endfunction

  task automatic model_reset();
    m_total = 0;
    m_pre   = 0;
    m_flag  = 1'b0;
  endtask

  task automatic model_edge();
    int mm;
    int ss;
    if (bus.clear) begin
      model_reset();
    end else if (bus.enable_decrement || bus.enable) begin
      m_pre = m_pre + 1;
      if (m_pre == TICK_DIV) begin
        m_pre = 0;
        if (bus.enable_decrement) begin
          if (m_total > 0) m_total = m_total - 1;
        end else if (m_total < 5999) begin
          m_total = m_total + 1;
        end
      end
      if (bus.enable_decrement && m_total == 0) m_flag = 1'b1;
    end else begin
      m_pre = 0;
      if (bus.enable_increment) begin
        mm = m_total / 60;
        ss = m_total % 60;
        if (bus.adj_min) mm = (mm + 1) % 100;
        if (bus.adj_sec) ss = (ss + 1) % 60;
        m_total = mm * 60 + ss;
      end
    end
  endtask

  task automatic cycle(input logic clr, input logic en, input logic inc, input logic dec,
                       input logic a_sec, input logic a_min);
    bus.clear            = clr;
    bus.enable           = en;
    bus.enable_increment = inc;
    bus.enable_decrement = dec;
    bus.adj_sec          = a_sec;
    bus.adj_min          = a_min;
    @(posedge clk);
    if (rst) model_reset();
    else     model_edge();
    #1;
  endtask

  task automatic preload(input int mm, input int ss);
    cycle(1, 0, 0, 0, 0, 0);
    for (int i = 0; i < mm; i++) cycle(0, 0, 1, 0, 0, 1);
    for (int i = 0; i < ss; i++) cycle(0, 0, 1, 0, 1, 0);
    cycle(0, 0, 0, 0, 0, 0);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    for (int i = 0; i < 3; i++) cycle(0, 0, 0, 0, 0, 0);
    rst = 1'b0;
    for (int i = 0; i < 20; i++) begin
      cycle(0, 0, 0, 0, 0, 0);
      checks++;
      if (bus.time_bcd !== 16'h0000 || bus.flag !== 1'b0 || bus.tick !== 1'b0) begin
        failures++;
        $display("FAIL reset_idle cycle %0d: time=%h flag=%b tick=%b, need 0000/0/0",
                 i, bus.time_bcd, bus.flag, bus.tick);
      end
    end
  endtask

  task automatic test_count_up();
    cycle(1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 244; i++) begin
      cycle(0, 1, 0, 0, 0, 0);
      checks++;
      if (bus.time_bcd !== to_bcd(m_total) || bus.tick !== (m_pre == TICK_DIV - 1)) begin
        failures++;
        $display("FAIL count_up cycle %0d: time=%h tick=%b, need %h/%b",
                 i, bus.time_bcd, bus.tick, to_bcd(m_total), (m_pre == TICK_DIV - 1));
      end
    end
    checks++;
    if (bus.time_bcd !== 16'h0101) begin
      failures++;
      $display("FAIL count_up_61: time=%h, need 0101", bus.time_bcd);
    end
    preload(99, 58);
    checks++;
    if (bus.time_bcd !== 16'h9958) begin
      failures++;
      $display("FAIL preload_9958: time=%h, need 9958", bus.time_bcd);
    end
    for (int i = 0; i < 2 * TICK_DIV; i++) cycle(0, 1, 0, 0, 0, 0);
    checks++;
    if (bus.time_bcd !== 16'h9959) begin
      failures++;
      $display("FAIL count_up_9959: time=%h, need 9959", bus.time_bcd);
    end
    for (int i = 0; i < 3 * TICK_DIV; i++) begin
      cycle(0, 1, 0, 0, 0, 0);
      checks++;
      if (bus.time_bcd !== 16'h9959 || bus.tick !== (m_pre == TICK_DIV - 1)) begin
        failures++;
        $display("FAIL saturate cycle %0d: time=%h tick=%b, need 9959/%b",
                 i, bus.time_bcd, bus.tick, (m_pre == TICK_DIV - 1));
      end
    end
  endtask

  task automatic test_input();
    cycle(1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) cycle(0, 0, 1, 0, 0, 1);
    for (int i = 0; i < 59; i++) cycle(0, 0, 1, 0, 1, 0);
    checks++;
    if (bus.time_bcd !== 16'h0359) begin
      failures++;
      $display("FAIL input_0359: time=%h, need 0359", bus.time_bcd);
    end
    cycle(0, 0, 1, 0, 1, 0);
    checks++;
    if (bus.time_bcd !== 16'h0300) begin
      failures++;
      $display("FAIL input_sec_wrap: time=%h, need 0300", bus.time_bcd);
    end
    cycle(0, 0, 0, 0, 1, 1);
    checks++;
    if (bus.time_bcd !== 16'h0300) begin
      failures++;
      $display("FAIL adj_outside_input: time=%h, need 0300", bus.time_bcd);
    end
    cycle(0, 0, 1, 0, 1, 1);
    checks++;
    if (bus.time_bcd !== 16'h0401) begin
      failures++;
      $display("FAIL adj_both: time=%h, need 0401", bus.time_bcd);
    end
    preload(99, 0);
    cycle(0, 0, 1, 0, 0, 1);
    checks++;
    if (bus.time_bcd !== 16'h0000) begin
      failures++;
      $display("FAIL min_wrap: time=%h, need 0000", bus.time_bcd);
    end
  endtask

  task automatic test_count_down();
    preload(1, 0);
    for (int i = 1; i <= 60 * TICK_DIV; i++) begin
      cycle(0, 0, 0, 1, 0, 0);
      if (i == TICK_DIV) begin
        checks++;
        if (bus.time_bcd !== 16'h0059) begin
          failures++;
          $display("FAIL down_first_tick: time=%h, need 0059", bus.time_bcd);
        end
      end
      if (i == 60 * TICK_DIV - 1) begin
        checks++;
        if (bus.time_bcd !== 16'h0001 || bus.flag !== 1'b0) begin
          failures++;
          $display("FAIL down_before_zero: time=%h flag=%b, need 0001/0", bus.time_bcd, bus.flag);
        end
      end
      checks++;
      if (bus.time_bcd !== to_bcd(m_total) || bus.flag !== m_flag) begin
        failures++;
        $display("FAIL count_down cycle %0d: time=%h flag=%b, need %h/%b",
                 i, bus.time_bcd, bus.flag, to_bcd(m_total), m_flag);
      end
    end
    checks++;
    if (bus.time_bcd !== 16'h0000 || bus.flag !== 1'b1) begin
      failures++;
      $display("FAIL down_zero: time=%h flag=%b, need 0000/1", bus.time_bcd, bus.flag);
    end
    for (int i = 0; i < 2 * TICK_DIV; i++) cycle(0, 0, 0, 1, 0, 0);
    cycle(0, 0, 0, 0, 0, 0);
    checks++;
    if (bus.time_bcd !== 16'h0000 || bus.flag !== 1'b1) begin
      failures++;
      $display("FAIL down_hold: time=%h flag=%b, need 0000/1", bus.time_bcd, bus.flag);
    end
  endtask

  task automatic test_clear();
    preload(0, 7);
    for (int i = 0; i < 2; i++) cycle(0, 1, 0, 0, 0, 0);
    cycle(1, 1, 0, 1, 0, 0);
    checks++;
    if (bus.time_bcd !== 16'h0000 || bus.flag !== 1'b0 || bus.tick !== 1'b0) begin
      failures++;
      $display("FAIL clear_priority: time=%h flag=%b tick=%b, need 0000/0/0",
               bus.time_bcd, bus.flag, bus.tick);
    end
    cycle(0, 0, 0, 1, 0, 0);
    cycle(1, 1, 1, 1, 1, 1);
    checks++;
    if (bus.flag !== 1'b0 || bus.time_bcd !== 16'h0000) begin
      failures++;
      $display("FAIL clear_flag: flag=%b time=%h, need 0/0000", bus.flag, bus.time_bcd);
    end
    for (int i = 1; i <= TICK_DIV; i++) begin
      cycle(0, 1, 0, 0, 0, 0);
      checks++;
      if (bus.tick !== (i == TICK_DIV - 1)) begin
        failures++;
        $display("FAIL prescaler_restart edge %0d: tick=%b, need %b", i, bus.tick, (i == TICK_DIV - 1));
      end
    end
    checks++;
    if (bus.time_bcd !== 16'h0001) begin
      failures++;
      $display("FAIL clear_then_up: time=%h, need 0001", bus.time_bcd);
    end
  endtask

  task automatic test_async_reset();
    preload(0, 5);
    for (int i = 0; i < TICK_DIV + 2; i++) cycle(0, 0, 0, 1, 0, 0);
    checks++;
    if (bus.time_bcd !== 16'h0004) begin
      failures++;
      $display("FAIL pre_rst_value: time=%h, need 0004", bus.time_bcd);
    end
    #2;
    rst = 1'b1;
    #1;
    model_reset();
    checks++;
    if (bus.time_bcd !== 16'h0000 || bus.flag !== 1'b0 || bus.tick !== 1'b0) begin
      failures++;
      $display("FAIL async_rst: time=%h flag=%b tick=%b, need 0000/0/0",
               bus.time_bcd, bus.flag, bus.tick);
    end
    cycle(0, 0, 0, 1, 0, 0);
    rst = 1'b0;
    for (int i = 0; i < TICK_DIV; i++) cycle(0, 1, 0, 0, 0, 0);
    checks++;
    if (bus.time_bcd !== 16'h0001 || bus.flag !== 1'b0) begin
      failures++;
      $display("FAIL resume_after_rst: time=%h flag=%b, need 0001/0", bus.time_bcd, bus.flag);
    end
  endtask

  task automatic test_random();
    logic clr, en, inc, dec, a_sec, a_min;
    cycle(1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 800; i++) begin
      clr   = ($urandom_range(0, 49) == 0);
      dec   = ($urandom_range(0, 5) == 0);
      en    = ($urandom_range(0, 2) != 0);
      inc   = ($urandom_range(0, 1) == 0);
      a_sec = ($urandom_range(0, 1) == 0);
      a_min = ($urandom_range(0, 3) == 0);
      cycle(clr, en, inc, dec, a_sec, a_min);
      checks++;
      if (bus.time_bcd !== to_bcd(m_total) || bus.flag !== m_flag ||
          bus.tick !== (m_pre == TICK_DIV - 1)) begin
        failures++;
        $display("FAIL random cycle %0d: time=%h flag=%b tick=%b, need %h/%b/%b",
                 i, bus.time_bcd, bus.flag, bus.tick, to_bcd(m_total), m_flag,
                 (m_pre == TICK_DIV - 1));
      end
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst      = 1'b1;
    bus.clear            = 1'b0;
    bus.enable           = 1'b0;
    bus.enable_increment = 1'b0;
    bus.enable_decrement = 1'b0;
    bus.adj_sec          = 1'b0;
    bus.adj_min          = 1'b0;
    model_reset();
    test_reset();
    test_count_up();
    test_input();
    test_count_down();
    test_clear();
    test_async_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
